// File: rtl/uart_rx_framer.sv
// uart_rx_framer
//   Reassembles byte frames from a UART receiver and replays the payload on a
//   valid/ready stream once the checksum has been verified.
//
//   Frame: 0xA5, LEN, LEN payload bytes, CHK with CHK = (LEN + sum(payload)) mod 256.
//
//   Optional feature: define UART_RX_FRAMER_TIMEOUT_EN to abort a partial
//   frame after TIMEOUT_TICKS idle cycles (error code 2). Without the macro a
//   partial frame waits indefinitely.
//
// Ports
//   Clock       in   sole clock, rising edge
//   Reset       in   asynchronous active-low reset
//   RxDone_i    in   one-cycle strobe: RxData_i holds a received byte
//   RxData_i    in   received byte
//   Data_o      out  payload byte
//   Valid_o     out  Data_o valid
//   Ready_i     in   consumer accepts Data_o
//   Last_o      out  final payload byte (qualified by Valid_o)
//   FrameOk_o   out  one-cycle pulse: frame accepted
//   FrameErr_o  out  one-cycle pulse: frame or byte rejected
//   ErrCode_o   out  cause of last error: 0 BADLEN, 1 CHECKSUM, 2 TIMEOUT, 3 OVERRUN
module uart_rx_framer #(
    parameter int MAX_LEN       = 16,
    parameter int TIMEOUT_TICKS = 10000
) (
    input  logic       Clock,
    input  logic       Reset,
    input  logic       RxDone_i,
    input  logic [7:0] RxData_i,
    output logic [7:0] Data_o,
    output logic       Valid_o,
    input  logic       Ready_i,
    output logic       Last_o,
    output logic       FrameOk_o,
    output logic       FrameErr_o,
    output logic [1:0] ErrCode_o
);

    localparam int         IDX_W     = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
    localparam logic [7:0] MAX_LEN_B = 8'(MAX_LEN);
    localparam logic [7:0] SOF       = 8'hA5;

    localparam logic [1:0] ERR_BADLEN   = 2'd0;
    localparam logic [1:0] ERR_CHECKSUM = 2'd1;
    localparam logic [1:0] ERR_OVERRUN  = 2'd3;

    if (MAX_LEN < 1 || MAX_LEN > 255 || TIMEOUT_TICKS < 1) begin : g_bad_param
        $error("uart_rx_framer: MAX_LEN must be 1..255 and TIMEOUT_TICKS >= 1");
    end

    typedef enum logic [2:0] {
        S_IDLE,
        S_LEN,
        S_PAYLOAD,
        S_CHECK,
        S_EMIT
    } state_t;

    state_t     state;
    logic [7:0] len_q;
    logic [7:0] cnt_q;      // write index in PAYLOAD, read index in EMIT
    logic [7:0] sum_q;
    logic [7:0] buf_q [MAX_LEN];
    logic [7:0] nxt_idx;

    assign nxt_idx = cnt_q + 8'd1;

`ifdef UART_RX_FRAMER_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_TICKS + 1);
    logic [TW-1:0] tmo_q;
    logic          tmo_active;

    assign tmo_active = (state == S_LEN) || (state == S_PAYLOAD) || (state == S_CHECK);
`endif

    // Payload storage carries no reset: it is only read after being written
    // by the current frame.
    always_ff @(posedge Clock) begin
        if (state == S_PAYLOAD && RxDone_i)
            buf_q[cnt_q[IDX_W-1:0]] <= RxData_i;
    end

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            state      <= S_IDLE;
            len_q      <= 8'd0;
            cnt_q      <= 8'd0;
            sum_q      <= 8'd0;
            Data_o     <= 8'd0;
            Valid_o    <= 1'b0;
            Last_o     <= 1'b0;
            FrameOk_o  <= 1'b0;
            FrameErr_o <= 1'b0;
            ErrCode_o  <= 2'd0;
`ifdef UART_RX_FRAMER_TIMEOUT_EN
            tmo_q      <= '0;
`endif
        end else begin
            FrameOk_o  <= 1'b0;
            FrameErr_o <= 1'b0;

            case (state)
                S_IDLE: begin
                    if (RxDone_i && RxData_i == SOF)
                        state <= S_LEN;
                end

                S_LEN: begin
                    if (RxDone_i) begin
                        if (RxData_i == 8'd0 || RxData_i > MAX_LEN_B) begin
                            FrameErr_o <= 1'b1;
                            ErrCode_o  <= ERR_BADLEN;
                            state      <= S_IDLE;
                        end else begin
                            len_q <= RxData_i;
                            sum_q <= RxData_i;   // checksum covers LEN too
                            cnt_q <= 8'd0;
                            state <= S_PAYLOAD;
                        end
                    end
                end

                S_PAYLOAD: begin
                    if (RxDone_i) begin
                        sum_q <= sum_q + RxData_i;
                        if (cnt_q == len_q - 8'd1)
                            state <= S_CHECK;
                        else
                            cnt_q <= nxt_idx;
                    end
                end

                S_CHECK: begin
                    if (RxDone_i) begin
                        if (RxData_i == sum_q) begin
                            FrameOk_o <= 1'b1;
                            Valid_o   <= 1'b1;
                            Data_o    <= buf_q[0];
                            Last_o    <= (len_q == 8'd1);
                            cnt_q     <= 8'd0;
                            state     <= S_EMIT;
                        end else begin
                            FrameErr_o <= 1'b1;
                            ErrCode_o  <= ERR_CHECKSUM;
                            state      <= S_IDLE;
                        end
                    end
                end

                S_EMIT: begin
                    // Any byte here (including one coinciding with the final
                    // transfer) is lost; the stream itself is untouched.
                    if (RxDone_i) begin
                        FrameErr_o <= 1'b1;
                        ErrCode_o  <= ERR_OVERRUN;
                    end
                    if (Valid_o && Ready_i) begin
                        if (Last_o) begin
                            Valid_o <= 1'b0;
                            Last_o  <= 1'b0;
                            state   <= S_IDLE;
                        end else begin
                            cnt_q  <= nxt_idx;
                            Data_o <= buf_q[nxt_idx[IDX_W-1:0]];
                            Last_o <= (nxt_idx == len_q - 8'd1);
                        end
                    end
                end

                default: state <= S_IDLE;
            endcase

`ifdef UART_RX_FRAMER_TIMEOUT_EN
            // Counts idle cycles between strobes while a frame is being
            // collected; the abort overrides whatever the FSM chose above.
            if (tmo_active && !RxDone_i) begin
                if (tmo_q == TW'(TIMEOUT_TICKS - 1)) begin
                    tmo_q      <= '0;
                    FrameErr_o <= 1'b1;
                    ErrCode_o  <= 2'd2;
                    state      <= S_IDLE;
                end else begin
                    tmo_q <= tmo_q + TW'(1);
                end
            end else begin
                tmo_q <= '0;
            end
`endif
        end
    end

endmodule

// File: tb/tb_uart_rx_framer.sv
// Directed bench for uart_rx_framer. Inputs change 1 time unit after the
// rising edge; a negedge monitor records pulses and handshake beats.
module tb_uart_rx_framer;

    localparam int TO = 40;

    logic       Clock;
    logic       Reset;
    logic       RxDone_i;
    logic [7:0] RxData_i;
    logic [7:0] Data_o;
    logic       Valid_o;
    logic       Ready_i;
    logic       Last_o;
    logic       FrameOk_o;
    logic       FrameErr_o;
    logic [1:0] ErrCode_o;

    int n_cmp  = 0;
    int n_fail = 0;

    uart_rx_framer #(.MAX_LEN(16), .TIMEOUT_TICKS(TO)) dut (
        .Clock(Clock), .Reset(Reset), .RxDone_i(RxDone_i), .RxData_i(RxData_i),
        .Data_o(Data_o), .Valid_o(Valid_o), .Ready_i(Ready_i), .Last_o(Last_o),
        .FrameOk_o(FrameOk_o), .FrameErr_o(FrameErr_o), .ErrCode_o(ErrCode_o)
    );

    initial begin
        Clock = 1'b0;
        forever #5 Clock = ~Clock;
    end

    // ---------------- monitor ----------------
    int         cyc = 0;
    int         ok_cnt = 0;
    int         err_cnt = 0;
    int         valid_cnt = 0;
    bit         both_seen = 1'b0;
    logic [7:0] bq [$];
    bit         lq [$];
    int         cq [$];

    always @(posedge Clock) cyc++;

    always @(negedge Clock) begin
        if (FrameOk_o) ok_cnt++;
        if (FrameErr_o) err_cnt++;
        if (FrameOk_o && FrameErr_o) both_seen = 1'b1;
        if (Valid_o) valid_cnt++;
        if (Valid_o && Ready_i) begin
            bq.push_back(Data_o);
            lq.push_back(Last_o);
            cq.push_back(cyc);
        end
    end

    // Called 1 unit after a rising edge; returns 1 unit after the edge that
    // sampled the strobe, so registered reactions are visible on return.
    task automatic send_byte(input logic [7:0] b);
        RxDone_i = 1'b1;
        RxData_i = b;
        @(posedge Clock); #1;
        RxDone_i = 1'b0;
        RxData_i = 8'h00;
    endtask

    task automatic send_basic();
        send_byte(8'hA5); send_byte(8'h03); send_byte(8'h11);
        send_byte(8'h22); send_byte(8'h33); send_byte(8'h69);
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge Clock);
        #1;
    endtask

    // Checks three beats 11/22/33 starting at queue index b0.
    task automatic check_basic_beats(input string nm, input int b0);
        logic [7:0] exp [3];
        exp[0] = 8'h11; exp[1] = 8'h22; exp[2] = 8'h33;
        n_cmp++;
        if (bq.size() - b0 !== 3) begin
            n_fail++; $display("FAIL %s_nbeats: got %0d want 3", nm, bq.size() - b0);
        end else begin
            for (int i = 0; i < 3; i++) begin
                n_cmp++;
                if (bq[b0+i] !== exp[i] || lq[b0+i] !== (i == 2)) begin
                    n_fail++;
                    $display("FAIL %s_beat%0d: got %h/last=%b want %h/last=%b",
                             nm, i, bq[b0+i], lq[b0+i], exp[i], (i == 2));
                end
            end
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        Reset = 1'b0; RxDone_i = 1'b0; RxData_i = 8'h00; Ready_i = 1'b0;
        #12;
        n_cmp++;
        if ({Valid_o, Last_o, FrameOk_o, FrameErr_o, Data_o, ErrCode_o} !== 14'd0) begin
            n_fail++;
            $display("FAIL reset_outputs: got v%b l%b ok%b err%b d%h c%0d want all 0",
                     Valid_o, Last_o, FrameOk_o, FrameErr_o, Data_o, ErrCode_o);
        end
        @(posedge Clock); #1;
        Reset = 1'b1;
        idle(2);
    endtask

    task automatic test_basic();
        int b0 = bq.size();
        int o0 = ok_cnt;
        int e0 = err_cnt;
        Ready_i = 1'b1;
        send_byte(8'h00);
        send_basic();
        n_cmp++;
        if (FrameOk_o !== 1'b1 || Valid_o !== 1'b1 || Data_o !== 8'h11 || Last_o !== 1'b0) begin
            n_fail++;
            $display("FAIL basic_first: got ok%b v%b d%h l%b want ok1 v1 d11 l0",
                     FrameOk_o, Valid_o, Data_o, Last_o);
        end
        idle(6);
        check_basic_beats("basic", b0);
        n_cmp++;
        if (bq.size() - b0 == 3 && (cq[b0+1] != cq[b0] + 1 || cq[b0+2] != cq[b0] + 2)) begin
            n_fail++;
            $display("FAIL basic_consecutive: got cycles %0d %0d %0d want consecutive",
                     cq[b0], cq[b0+1], cq[b0+2]);
        end
        n_cmp++;
        if (ok_cnt - o0 !== 1 || err_cnt - e0 !== 0 || Valid_o !== 1'b0) begin
            n_fail++;
            $display("FAIL basic_pulses: got ok=%0d err=%0d v%b want 1 0 0",
                     ok_cnt - o0, err_cnt - e0, Valid_o);
        end
    endtask

    task automatic test_backpressure();
        int b0 = bq.size();
        Ready_i = 1'b0;
        send_basic();
        for (int i = 0; i < 5; i++) begin
            n_cmp++;
            if (Valid_o !== 1'b1 || Data_o !== 8'h11 || Last_o !== 1'b0) begin
                n_fail++;
                $display("FAIL bp_hold%0d: got v%b d%h l%b want v1 d11 l0",
                         i, Valid_o, Data_o, Last_o);
            end
            idle(1);
        end
        Ready_i = 1'b1;
        idle(6);
        check_basic_beats("bp", b0);
    endtask

    task automatic test_checksum();
        int v0 = valid_cnt;
        int e0 = err_cnt;
        int o0 = ok_cnt;
        Ready_i = 1'b1;
        send_byte(8'hA5); send_byte(8'h03); send_byte(8'h11);
        send_byte(8'h22); send_byte(8'h33); send_byte(8'h00);
        n_cmp++;
        if (FrameErr_o !== 1'b1 || ErrCode_o !== 2'd1) begin
            n_fail++; $display("FAIL chk_err: got err%b code%0d want err1 code1", FrameErr_o, ErrCode_o);
        end
        idle(5);
        n_cmp++;
        if (valid_cnt != v0 || ok_cnt != o0 || err_cnt - e0 !== 1) begin
            n_fail++;
            $display("FAIL chk_novalid: got valid_cycles=%0d ok=%0d err=%0d want 0 0 1",
                     valid_cnt - v0, ok_cnt - o0, err_cnt - e0);
        end
    endtask

    task automatic test_badlen();
        int e0 = err_cnt;
        send_byte(8'hA5); send_byte(8'h00);
        n_cmp++;
        if (FrameErr_o !== 1'b1 || ErrCode_o !== 2'd0) begin
            n_fail++; $display("FAIL badlen_zero: got err%b code%0d want err1 code0", FrameErr_o, ErrCode_o);
        end
        // force the held code away from 0 so the next check is meaningful
        send_byte(8'hA5); send_byte(8'h01); send_byte(8'h01); send_byte(8'h00);
        send_byte(8'hA5); send_byte(8'h11);
        n_cmp++;
        if (FrameErr_o !== 1'b1 || ErrCode_o !== 2'd0) begin
            n_fail++; $display("FAIL badlen_17: got err%b code%0d want err1 code0", FrameErr_o, ErrCode_o);
        end
        idle(2);
        n_cmp++;
        if (err_cnt - e0 !== 3 || Valid_o !== 1'b0) begin
            n_fail++; $display("FAIL badlen_count: got err=%0d v%b want 3 0", err_cnt - e0, Valid_o);
        end
    endtask

    task automatic test_len_bounds();
        int b0 = bq.size();
        int o0 = ok_cnt;
        Ready_i = 1'b1;
        // LEN = 1: the only beat is also the last
        send_byte(8'hA5); send_byte(8'h01); send_byte(8'h7F); send_byte(8'h80);
        n_cmp++;
        if (Valid_o !== 1'b1 || Data_o !== 8'h7F || Last_o !== 1'b1) begin
            n_fail++; $display("FAIL len1_beat: got v%b d%h l%b want v1 d7f l1", Valid_o, Data_o, Last_o);
        end
        idle(3);
        // LEN = MAX_LEN = 16, payload 0..15, CHK = 16 + 120 = 0x88
        b0 = bq.size();
        send_byte(8'hA5); send_byte(8'h10);
        for (int i = 0; i < 16; i++) send_byte(8'(i));
        send_byte(8'h88);
        idle(20);
        n_cmp++;
        if (bq.size() - b0 !== 16 || ok_cnt - o0 !== 2) begin
            n_fail++; $display("FAIL len16_count: got beats=%0d ok=%0d want 16 2", bq.size() - b0, ok_cnt - o0);
        end else begin
            for (int i = 0; i < 16; i++) begin
                n_cmp++;
                if (bq[b0+i] !== 8'(i) || lq[b0+i] !== (i == 15)) begin
                    n_fail++;
                    $display("FAIL len16_beat%0d: got %h/last=%b want %h/last=%b",
                             i, bq[b0+i], lq[b0+i], 8'(i), (i == 15));
                end
            end
        end
    endtask

    task automatic test_overrun();
        int b0 = bq.size();
        int o0 = ok_cnt;
        Ready_i = 1'b0;
        send_basic();
        send_byte(8'h55);
        n_cmp++;
        if (FrameErr_o !== 1'b1 || ErrCode_o !== 2'd3 || Valid_o !== 1'b1 || Data_o !== 8'h11) begin
            n_fail++;
            $display("FAIL ovr_err: got err%b code%0d v%b d%h want err1 code3 v1 d11",
                     FrameErr_o, ErrCode_o, Valid_o, Data_o);
        end
        Ready_i = 1'b1;
        idle(6);
        check_basic_beats("ovr", b0);
        n_cmp++;
        if (ok_cnt - o0 !== 1) begin
            n_fail++; $display("FAIL ovr_ok: got %0d want 1", ok_cnt - o0);
        end
    endtask

    // Byte strobed in the same cycle as the final transfer: dropped as overrun.
    task automatic test_back_to_back();
        int b0 = bq.size();
        Ready_i = 1'b0;
        send_byte(8'hA5); send_byte(8'h02); send_byte(8'hAA); send_byte(8'hBB);
        send_byte(8'h67);
        Ready_i = 1'b1;
        idle(1);                       // AA transferred, BB/last now presented
        send_byte(8'h77);              // lands on the final transfer edge
        n_cmp++;
        if (FrameErr_o !== 1'b1 || ErrCode_o !== 2'd3 || Valid_o !== 1'b0) begin
            n_fail++;
            $display("FAIL b2b_last: got err%b code%0d v%b want err1 code3 v0", FrameErr_o, ErrCode_o, Valid_o);
        end
        idle(3);
        n_cmp++;
        if (bq.size() - b0 !== 2 || bq[b0] !== 8'hAA || bq[b0+1] !== 8'hBB || lq[b0+1] !== 1'b1) begin
            n_fail++; $display("FAIL b2b_beats: got %0d beats want AA BB(last)", bq.size() - b0);
        end
    endtask

    task automatic test_reset_midframe();
        int b0;
        int o0;
        Ready_i = 1'b1;
        send_byte(8'hA5); send_byte(8'h03); send_byte(8'h11);
        Reset = 1'b0;
        #1;
        n_cmp++;
        if ({Valid_o, Last_o, FrameOk_o, FrameErr_o, Data_o, ErrCode_o} !== 14'd0) begin
            n_fail++;
            $display("FAIL rst_mid_outputs: got v%b l%b ok%b err%b d%h c%0d want all 0",
                     Valid_o, Last_o, FrameOk_o, FrameErr_o, Data_o, ErrCode_o);
        end
        @(posedge Clock); #1;
        Reset = 1'b1;
        idle(1);
        b0 = bq.size();
        o0 = ok_cnt;
        send_basic();
        idle(6);
        n_cmp++;
        if (ok_cnt - o0 !== 1) begin
            n_fail++; $display("FAIL rst_mid_ok: got %0d want 1", ok_cnt - o0);
        end
        check_basic_beats("rst_mid", b0);
    endtask

    task automatic test_timeout();
        int b0;
        int o0;
        int e0 = err_cnt;
        Ready_i = 1'b1;
        send_byte(8'hA5); send_byte(8'h02); send_byte(8'h11);
`ifdef UART_RX_FRAMER_TIMEOUT_EN
        idle(TO - 1);
        n_cmp++;
        if (FrameErr_o !== 1'b0) begin
            n_fail++; $display("FAIL tmo_early: got err%b want 0", FrameErr_o);
        end
        idle(1);
        n_cmp++;
        if (FrameErr_o !== 1'b1 || ErrCode_o !== 2'd2) begin
            n_fail++; $display("FAIL tmo_err: got err%b code%0d want err1 code2", FrameErr_o, ErrCode_o);
        end
        b0 = bq.size();
        o0 = ok_cnt;
        send_basic();
        idle(6);
        n_cmp++;
        if (ok_cnt - o0 !== 1) begin
            n_fail++; $display("FAIL tmo_recover: got ok=%0d want 1", ok_cnt - o0);
        end
        check_basic_beats("tmo", b0);
`else
        idle(3 * TO);
        n_cmp++;
        if (err_cnt != e0) begin
            n_fail++; $display("FAIL notmo_err: got err=%0d want 0", err_cnt - e0);
        end
        send_byte(8'h22); send_byte(8'h35);
        n_cmp++;
        if (FrameOk_o !== 1'b1 || Data_o !== 8'h11) begin
            n_fail++; $display("FAIL notmo_ok: got ok%b d%h want ok1 d11", FrameOk_o, Data_o);
        end
        idle(4);
        b0 = 0; o0 = 0;
`endif
    endtask

    initial begin
        test_reset();
        test_basic();
        test_backpressure();
        test_checksum();
        test_badlen();
        test_len_bounds();
        test_overrun();
        test_back_to_back();
        test_reset_midframe();
        test_timeout();
        n_cmp++;
        if (both_seen !== 1'b0) begin
            n_fail++; $display("FAIL ok_err_exclusive: got both high=%b want 0", both_seen);
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/uart_rx_framer.md
UART_RX_FRAMER -- requirements
Module: uart_rx_framer

Interface
REQ-001 SHALL have parameter MAX_LEN, default 16: maximum payload length in bytes (1..255).
REQ-002 SHALL have parameter TIMEOUT_TICKS, default 10000: inter-byte timeout, in Clock cycles.
REQ-003 SHALL have port Clock  input  1  sole clock; all logic on the rising edge.
REQ-004 SHALL have port Reset  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port RxDone_i  input  1  one-cycle strobe from the UART receiver: a byte is available.
REQ-006 SHALL have port RxData_i  input  8  received byte; valid only while RxDone_i=1.
REQ-007 SHALL have port Data_o  output  8  payload byte to the downstream consumer.
REQ-008 SHALL have port Valid_o  output  1  Data_o is valid.
REQ-009 SHALL have port Ready_i  input  1  the consumer accepts Data_o.
REQ-010 SHALL have port Last_o  output  1  marks the final payload byte; qualified by Valid_o.
REQ-011 SHALL have port FrameOk_o  output  1  one-cycle pulse: a frame passed all checks.
REQ-012 SHALL have port FrameErr_o  output  1  one-cycle pulse: a frame or byte was rejected.
REQ-013 SHALL have port ErrCode_o  output  2  error cause, held until the next FrameErr_o: 0 BADLEN, 1 CHECKSUM, 2 TIMEOUT, 3 OVERRUN.

Function
REQ-014 SHALL accept frames of the form 0xA5, LEN, LEN payload bytes, CHK, where CHK = (LEN + sum of payload bytes) mod 256.
REQ-015 SHALL implement the FSM states IDLE, LEN, PAYLOAD, CHECK and EMIT; only bytes with RxDone_i=1 advance the FSM.
REQ-016 IDLE SHALL discard every byte except 0xA5; 0xA5 SHALL move the FSM to LEN.
REQ-017 In LEN, a value of 0 or greater than MAX_LEN SHALL pulse FrameErr_o with code 0 and return to IDLE; any other value SHALL be stored and move the FSM to PAYLOAD.
REQ-018 PAYLOAD SHALL write bytes into an internal MAX_LEN x 8 buffer at index 0..LEN-1; the byte at index LEN-1 SHALL move the FSM to CHECK.
REQ-019 In CHECK, the byte SHALL be compared with the 8-bit running sum, which wraps modulo 256.
REQ-020 On a CHECK mismatch, the block SHALL pulse FrameErr_o with code 1, return to IDLE, and never assert Valid_o for that frame.
REQ-021 On a CHECK match with the strobe at cycle N, the block SHALL pulse FrameOk_o at N+1, enter EMIT, and assert Valid_o at N+1 with buffer[0].
REQ-022 EMIT SHALL obey the valid/ready handshake: a transfer occurs when Valid_o=1 and Ready_i=1; Data_o and Last_o SHALL hold stable while Valid_o=1 and Ready_i=0.
REQ-023 After a transfer, the next byte SHALL appear in the following cycle; Valid_o SHALL never deassert mid-frame without a transfer.
REQ-024 Last_o SHALL be 1 only with buffer[LEN-1]; its transfer SHALL drop Valid_o and return the FSM to IDLE in the next cycle.
REQ-025 A byte arriving during EMIT SHALL be dropped and SHALL pulse FrameErr_o with code 3; the emission SHALL continue unaffected.
REQ-026 A byte arriving in the same cycle as the final transfer SHALL be treated as received in EMIT (dropped, code 3).
REQ-027 FrameOk_o and FrameErr_o SHALL never be high in the same cycle.

Reset
REQ-028 Reset=0 SHALL immediately (asynchronously) force the FSM to IDLE and clear Valid_o, Last_o, FrameOk_o, FrameErr_o, Data_o, ErrCode_o, the sum, the counters and the timeout counter to 0.
REQ-029 Reset mid-frame or mid-EMIT SHALL abandon the frame with no further output; the buffer contents need not be cleared.
REQ-030 Operation SHALL resume on the first rising Clock edge after Reset returns to 1.

Configuration
REQ-031 Macro UART_RX_FRAMER_TIMEOUT_EN SHALL compile the timeout feature in when defined.
REQ-032 When defined: in LEN, PAYLOAD or CHECK, a cycle counter SHALL reset on every RxDone_i and count otherwise.
REQ-033 When defined: on reaching TIMEOUT_TICKS, the block SHALL pulse FrameErr_o with code 2 and return to IDLE; the count SHALL be inactive in IDLE and EMIT.
REQ-034 When undefined: the timeout counter SHALL not exist, code 2 SHALL never occur, and partial frames SHALL wait indefinitely.

Verification
REQ-035 Scenario: 0x00, A5 03 11 22 33 69, Ready_i=1 -> one FrameOk_o pulse; beats 11, 22, 33 on consecutive cycles; Last_o with 33.
REQ-036 Scenario: same frame, Ready_i=0 for 5 cycles after Valid_o -> Data_o held at 0x11 with Valid_o=1; then 3 beats.
REQ-037 Scenario: A5 03 11 22 33 00 -> FrameErr_o with ErrCode_o=1, Valid_o never asserted; A5 00 and A5 11 (MAX_LEN=16) -> code 0 each.
REQ-038 Scenario: macro defined, A5 02 11 then idle TIMEOUT_TICKS cycles -> FrameErr_o with code 2; a following valid frame is accepted.
REQ-039 Scenario: byte 0x55 during EMIT with Ready_i=0 -> FrameErr_o with code 3; the payload is still delivered intact.
REQ-040 Scenario: Reset pulse after A5 03 11 -> all outputs 0; the next full valid frame produces FrameOk_o.
